// File: rtl/display_feedback_seq_pkg.sv
// display_pkg: shared constants for the 7-segment feedback driver.
//   - Glyph localparams, bit order {g,f,e,d,c,b,a}, active low.
//   - HEX_GLYPH: 0-F table, indexed by nibble value.
//   - dstate_t: display FSM state encoding.
//   - ST_*: game-state encodings produced by the game controller.
package display_pkg;

  localparam logic [6:0] GLY_BLANK = 7'b1111111;
  localparam logic [6:0] GLY_DASH  = 7'b0111111;
  localparam logic [6:0] GLY_L     = 7'b1000111;
  localparam logic [6:0] GLY_O     = 7'b1000000;
  localparam logic [6:0] GLY_S     = 7'b0010010;
  localparam logic [6:0] GLY_E     = 7'b0000110;
  localparam logic [6:0] GLY_H     = 7'b0001001;
  localparam logic [6:0] GLY_I     = 7'b1111001;

  // Entry [15] is first in the concatenation, so the list runs F down to 0.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic [2:0] {
    D_BLANK = 3'd0,
    D_GUESS = 3'd1,
    D_MSG   = 3'd2,
    D_REM   = 3'd3,
    D_WIN   = 3'd4,
    D_LOSE  = 3'd5
  } dstate_t;

  localparam logic [2:0] ST_IDLE     = 3'b000;
  localparam logic [2:0] ST_GUESS    = 3'b001;
  localparam logic [2:0] ST_FEEDBACK = 3'b010;
  localparam logic [2:0] ST_WIN      = 3'b011;

endpackage

// File: rtl/display_feedback_seq_if.sv
// display_feedback_seq_if: game controller <-> display driver bundle.
//   state[2:0]              game state (000 idle, 001 guess, 010 feedback, 011 win, 1xx lose)
//   guess[GUESS_W-1:0]      current guess, unsigned
//   fb_code[1:0]            00 too low, 01 too high, 1x none
//   remaining_guesses[3:0]  guesses left
//   seg_out[7*NUM_DIGITS-1:0] active-low segments, digit k at [7k+6:7k]
//   msg_busy                HI/LO hold timer running
// master = game controller side, slave = display driver side.
// NUM_DIGITS / GUESS_W must match the parameters of the attached driver.
interface display_feedback_seq_if #(
  parameter int NUM_DIGITS = 4,
  parameter int GUESS_W    = 7
) ();
  logic [2:0]              state;
  logic [GUESS_W-1:0]      guess;
  logic [1:0]              fb_code;
  logic [3:0]              remaining_guesses;
  logic [7*NUM_DIGITS-1:0] seg_out;
  logic                    msg_busy;

  modport master (
    output state, guess, fb_code, remaining_guesses,
    input  seg_out, msg_busy
  );

  modport slave (
    input  state, guess, fb_code, remaining_guesses,
    output seg_out, msg_busy
  );
endinterface

// File: rtl/display_feedback_seq_seg7_dec.sv
// seg7_dec: combinational 4-bit value to active-low 7-segment hex glyph.
//   val[3:0]  nibble to render
//   seg[6:0]  {g,f,e,d,c,b,a}, active low
module seg7_dec
  import display_pkg::*;
(
  input  logic [3:0] val,
  output logic [6:0] seg
);
  assign seg = HEX_GLYPH[val];
endmodule

// File: rtl/display_feedback_seq.sv
// display_feedback_seq: registered 7-segment feedback driver for the
// number-guessing game. Renders the guess in decimal, holds HI/LO for
// HOLD_CYCLES, blinks the win display, shows LOSE.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    display_feedback_seq_if.slave (state/guess/fb_code/remaining_guesses
//          in; seg_out/msg_busy out, both registered)
module display_feedback_seq
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int GUESS_W      = 7,
  parameter int HOLD_CYCLES  = 50_000_000,
  parameter int BLINK_PERIOD = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  display_feedback_seq_if.slave bus
);

  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam int BW = $clog2(BLINK_PERIOD) + 1;
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIOD - 1);

  dstate_t                      dstate, d_nxt;
  logic [2:0]                   prev_state;
  logic [HW-1:0]                hold_cnt, hold_nxt;
  logic [BW-1:0]                blink_cnt, blink_nxt;
  logic                         blink_on, phase_nxt;
  logic [NUM_DIGITS-1:0][6:0]   seg_q, seg_nxt;
  logic                         busy_q;

  // Double-dabble, 3 BCD digits; GUESS_W <= 9 keeps the value below 512.
  function automatic logic [11:0] bin2bcd(input logic [8:0] bin);
    logic [11:0] bcd;
    bcd = '0;
    for (int i = 8; i >= 0; i--) begin
      for (int n = 0; n < 3; n++)
        if (bcd[n*4 +: 4] >= 4'd5) bcd[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
      bcd = {bcd[10:0], bin[i]};
    end
    return bcd;
  endfunction

  logic [11:0]      bcd;
  logic [3:0][3:0]  dec_val;
  logic [3:0][6:0]  dec_seg;

  assign bcd     = bin2bcd(9'(bus.guess));
  assign dec_val = {bus.remaining_guesses, bcd};

  // Decoders 0..2 render the BCD digits, decoder 3 renders remaining_guesses.
  for (genvar g = 0; g < 4; g++) begin : g_dec
    seg7_dec u_dec (.val(dec_val[g]), .seg(dec_seg[g]));
  end

  // Next display state and counters. A change of game state always wins
  // over the hold/blink timers and restarts them.
  always_comb begin
    d_nxt     = dstate;
    hold_nxt  = hold_cnt;
    blink_nxt = blink_cnt;
    phase_nxt = blink_on;
    if (bus.state != prev_state) begin
      hold_nxt  = '0;
      blink_nxt = '0;
      phase_nxt = 1'b1;
      case (bus.state)
        ST_IDLE:     d_nxt = D_BLANK;
        ST_GUESS:    d_nxt = D_GUESS;
        ST_FEEDBACK: d_nxt = D_MSG;
        ST_WIN:      d_nxt = D_WIN;
        default:     d_nxt = D_LOSE;
      endcase
    end else begin
      case (dstate)
        D_MSG:
          if (hold_cnt == HOLD_LAST) d_nxt = D_REM;
          else                       hold_nxt = hold_cnt + 1'b1;
        D_WIN:
          if (blink_cnt == BLINK_LAST) begin
            blink_nxt = '0;
            phase_nxt = ~blink_on;
          end else begin
            blink_nxt = blink_cnt + 1'b1;
          end
        default: ;
      endcase
    end
  end

  // Glyphs are rendered from the next state so seg_out and msg_busy
  // switch on the same edge as the FSM.
  always_comb begin
    seg_nxt = {NUM_DIGITS{GLY_BLANK}};
    case (d_nxt)
      D_GUESS, D_WIN: begin
        seg_nxt[0] = dec_seg[0];
        if (bcd[11:4] != 8'd0) seg_nxt[1] = dec_seg[1];
        if (bcd[11:8] != 4'd0) seg_nxt[2] = dec_seg[2];
        if (d_nxt == D_GUESS)  seg_nxt[NUM_DIGITS-1] = dec_seg[3];
        else if (!phase_nxt)   seg_nxt = {NUM_DIGITS{GLY_BLANK}};
      end
      D_MSG:
        case (bus.fb_code)
          2'b00:   seg_nxt[1:0] = {GLY_L, GLY_O};
          2'b01:   seg_nxt[1:0] = {GLY_H, GLY_I};
          default: seg_nxt[1:0] = {GLY_DASH, GLY_DASH};
        endcase
      D_REM:   seg_nxt[NUM_DIGITS-1] = dec_seg[3];
      D_LOSE:  seg_nxt[3:0] = {GLY_L, GLY_O, GLY_S, GLY_E};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dstate     <= D_BLANK;
      prev_state <= ST_IDLE;
      hold_cnt   <= '0;
      blink_cnt  <= '0;
      blink_on   <= 1'b1;
      seg_q      <= {NUM_DIGITS{GLY_BLANK}};
      busy_q     <= 1'b0;
    end else begin
      dstate     <= d_nxt;
      prev_state <= bus.state;
      hold_cnt   <= hold_nxt;
      blink_cnt  <= blink_nxt;
      blink_on   <= phase_nxt;
      seg_q      <= seg_nxt;
      busy_q     <= (d_nxt == D_MSG);
    end
  end

  assign bus.seg_out  = seg_q;
  assign bus.msg_busy = busy_q;

endmodule

// File: tb/tb_display_feedback_seq.sv
// Directed bench: dut4 (4 digits, hold 4, blink 2) and dut6 (6 digits,
// hold 1, blink 3) share clock and reset.
module tb_display_feedback_seq;

  localparam logic [6:0] BL  = 7'b1111111;
  localparam logic [6:0] DSH = 7'b0111111;
  localparam logic [6:0] G0  = 7'b1000000;
  localparam logic [6:0] G1  = 7'b1111001;
  localparam logic [6:0] G2  = 7'b0100100;
  localparam logic [6:0] G4  = 7'b0011001;
  localparam logic [6:0] G5  = 7'b0010010;
  localparam logic [6:0] G7  = 7'b1111000;
  localparam logic [6:0] GA  = 7'b0001000;
  localparam logic [6:0] GH  = 7'b0001001;
  localparam logic [6:0] GI  = 7'b1111001;
  localparam logic [6:0] GL  = 7'b1000111;
  localparam logic [6:0] GO  = 7'b1000000;
  localparam logic [6:0] GS  = 7'b0010010;
  localparam logic [6:0] GE  = 7'b0000110;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  display_feedback_seq_if #(.NUM_DIGITS(4), .GUESS_W(7)) a4 ();
  display_feedback_seq_if #(.NUM_DIGITS(6), .GUESS_W(7)) a6 ();

  display_feedback_seq #(.NUM_DIGITS(4), .GUESS_W(7), .HOLD_CYCLES(4), .BLINK_PERIOD(2))
    dut4 (.clk(clk), .rst_n(rst_n), .bus(a4));
  display_feedback_seq #(.NUM_DIGITS(6), .GUESS_W(7), .HOLD_CYCLES(1), .BLINK_PERIOD(3))
    dut6 (.clk(clk), .rst_n(rst_n), .bus(a6));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [27:0] d4(input logic [6:0] g3, g2, g1, g0);
    return {g3, g2, g1, g0};
  endfunction

  function automatic logic [41:0] d6(input logic [6:0] g5, g4, g3, g2, g1, g0);
    return {g5, g4, g3, g2, g1, g0};
  endfunction

  initial begin
    a4.state = 3'b011; a4.guess = '0; a4.fb_code = 2'b10; a4.remaining_guesses = '0;
    a6.state = 3'b011; a6.guess = '0; a6.fb_code = 2'b10; a6.remaining_guesses = '0;
    rst_n = 1'b0;

    // reset
    step();
    chk("rst_seg4", a4.seg_out, d4(BL, BL, BL, BL));
    chk("rst_busy4", a4.msg_busy, 1'b0);
    chk("rst_seg6", a6.seg_out, d6(BL, BL, BL, BL, BL, BL));
    step();
    rst_n = 1'b1; a4.state = 3'b000; a6.state = 3'b000;
    step();
    chk("idle_blank", a4.seg_out, d4(BL, BL, BL, BL));
    step();
    chk("idle_blank2", a4.seg_out, d4(BL, BL, BL, BL));

    // guess rendering
    a4.state = 3'b001; a4.guess = 7'd42; a4.remaining_guesses = 4'd5;
    step();
    chk("guess42", a4.seg_out, d4(G5, BL, G4, G2));
    chk("guess_busy", a4.msg_busy, 1'b0);
    a4.guess = 7'd105;
    step();
    chk("guess105", a4.seg_out, d4(G5, G1, G0, G5));
    a4.guess = 7'd0; a4.remaining_guesses = 4'hA;
    step();
    chk("guess0", a4.seg_out, d4(GA, BL, BL, G0));
    a4.guess = 7'd7; a4.remaining_guesses = 4'd5;
    step();
    chk("guess7", a4.seg_out, d4(G5, BL, BL, G7));
    a4.guess = 7'd42;
    step();

    // feedback hold, HI for 4 cycles then remaining count
    a4.state = 3'b010; a4.fb_code = 2'b01;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_hi", a4.seg_out, d4(BL, BL, GH, GI));
      chk("hold_busy", a4.msg_busy, 1'b1);
    end
    step();
    chk("rem_seg", a4.seg_out, d4(G5, BL, BL, BL));
    chk("rem_busy", a4.msg_busy, 1'b0);
    step();
    chk("rem_stay", a4.seg_out, d4(G5, BL, BL, BL));

    // abort and re-entry
    a4.state = 3'b001;
    step();
    a4.state = 3'b010; a4.fb_code = 2'b00;
    step();
    chk("lo_seg", a4.seg_out, d4(BL, BL, GL, GO));
    chk("lo_busy", a4.msg_busy, 1'b1);
    a4.fb_code = 2'b10;
    step();
    chk("dash_seg", a4.seg_out, d4(BL, BL, DSH, DSH));
    a4.state = 3'b001;
    step();
    chk("abort_busy", a4.msg_busy, 1'b0);
    chk("abort_seg", a4.seg_out, d4(G5, BL, G4, G2));
    a4.state = 3'b010; a4.fb_code = 2'b01;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("reent_busy", a4.msg_busy, 1'b1);
    end
    step();
    chk("reent_end_busy", a4.msg_busy, 1'b0);
    chk("reent_end_seg", a4.seg_out, d4(G5, BL, BL, BL));

    // win blink: two cycles on, two off
    a4.state = 3'b011; a4.guess = 7'd0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("win_blink", a4.seg_out,
          ((i / 2) % 2 == 0) ? d4(BL, BL, BL, G0) : d4(BL, BL, BL, BL));
    end

    // reset mid-operation
    rst_n = 1'b0;
    step();
    chk("midrst_seg", a4.seg_out, d4(BL, BL, BL, BL));
    chk("midrst_busy", a4.msg_busy, 1'b0);
    rst_n = 1'b1; a4.state = 3'b000;
    step();
    chk("midrst_idle", a4.seg_out, d4(BL, BL, BL, BL));

    // 6-digit instance, single-cycle hold
    a6.state = 3'b001; a6.guess = 7'd42; a6.remaining_guesses = 4'd5;
    step();
    chk("g6_guess", a6.seg_out, d6(G5, BL, BL, BL, G4, G2));
    a6.state = 3'b010; a6.fb_code = 2'b01;
    step();
    chk("g6_hi", a6.seg_out, d6(BL, BL, BL, BL, GH, GI));
    chk("g6_busy", a6.msg_busy, 1'b1);
    step();
    chk("g6_rem", a6.seg_out, d6(G5, BL, BL, BL, BL, BL));
    chk("g6_busy_off", a6.msg_busy, 1'b0);

    // lose banner, stable
    a6.state = 3'b100;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("lose6", a6.seg_out, d6(BL, BL, GL, GO, GS, GE));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
